// File: rtl/frame_queue_mac.sv
// rtl/frame_queue_mac.sv - frame-gated FIFO between MAC byte stream and consumer
// Optional status outputs enabled by QUEUE_MAC_STATUS_EN.
module frame_queue_mac #(
    parameter int DATA_WIDTH   = 10,
    parameter int DEPTH        = 16,
    parameter int START_THRESH = DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_req,
    input  logic [DATA_WIDTH-1:0]   push_data,
    output logic                    push_ack,
    input  logic                    pop_req,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    pop_ack
`ifdef QUEUE_MAC_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [$clog2(DEPTH):0]  frames_stored
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(START_THRESH);
    localparam logic [AW:0] ONE_C    = {{AW{1'b0}}, 1'b1};

    typedef enum logic {IDLE, SEND} state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic [AW:0]           frames_q, frames_d;
    state_t                state_q, state_d;

    logic [AW:0] count;
    logic        full, empty;
    logic        push_fire, pop_fire;
    logic        push_last, pop_last;

    assign count     = wptr_q - rptr_q;
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign push_ack  = !full;
    assign pop_ack   = (state_q == SEND) && !empty;
    assign pop_data  = mem_q[rptr_q[AW-1:0]];
    assign push_fire = push_req && push_ack;
    assign pop_fire  = pop_req && pop_ack;
    assign push_last = push_fire && push_data[DATA_WIDTH-1];
    assign pop_last  = pop_fire && pop_data[DATA_WIDTH-1];

`ifdef QUEUE_MAC_STATUS_EN
    assign occupancy     = count;
    assign frames_stored = frames_q;
`endif

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        frames_d = frames_q;
        state_d  = state_q;
        if (push_fire) begin
            wptr_d = wptr_q + ONE_C;
        end
        if (pop_fire) begin
            rptr_d = rptr_q + ONE_C;
        end
        case ({push_last, pop_last})
            2'b10:   frames_d = frames_q + ONE_C;
            2'b01:   frames_d = frames_q - ONE_C;
            default: frames_d = frames_q;
        endcase
        // The threshold path lets a marker-less full queue drain instead of deadlocking.
        case (state_q)
            IDLE: begin
                if ((frames_q != '0) || (count >= THRESH_C)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (pop_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            frames_q <= '0;
            state_q  <= IDLE;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            frames_q <= frames_d;
            state_q  <= state_d;
        end
    end

    // Storage is never cleared; reset only discards it via the pointers.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_frame_queue_mac.sv
// tb/tb_frame_queue_mac.sv - directed self-checking bench for frame_queue_mac
module tb_frame_queue_mac;

    logic       clk;
    logic       a_reset, a_push_req, a_push_ack, a_pop_req, a_pop_ack;
    logic [9:0] a_push_data, a_pop_data;
    logic       b_reset, b_push_req, b_push_ack, b_pop_req, b_pop_ack;
    logic [9:0] b_push_data, b_pop_data;

    int checks = 0;
    int errors = 0;

    frame_queue_mac #(.DATA_WIDTH(10), .DEPTH(16), .START_THRESH(16)) u_dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .push_req  (a_push_req),
        .push_data (a_push_data),
        .push_ack  (a_push_ack),
        .pop_req   (a_pop_req),
        .pop_data  (a_pop_data),
        .pop_ack   (a_pop_ack)
    );

    frame_queue_mac #(.DATA_WIDTH(10), .DEPTH(16), .START_THRESH(4)) u_dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .push_req  (b_push_req),
        .push_data (b_push_data),
        .push_ack  (b_push_ack),
        .pop_req   (b_pop_req),
        .pop_data  (b_pop_data),
        .pop_ack   (b_pop_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_both();
        a_push_req = 0; a_pop_req = 0; b_push_req = 0; b_pop_req = 0;
        a_reset = 1; b_reset = 1;
        tick();
        tick();
        a_reset = 0; b_reset = 0;
    endtask

    task automatic test_reset();
        reset_both();
        checks++; if (a_push_ack !== 1'b1) begin errors++; $display("FAIL reset_a_push_ack got %b exp 1", a_push_ack); end
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL reset_a_pop_ack got %b exp 0", a_pop_ack); end
        checks++; if (b_push_ack !== 1'b1) begin errors++; $display("FAIL reset_b_push_ack got %b exp 1", b_push_ack); end
        checks++; if (b_pop_ack !== 1'b0) begin errors++; $display("FAIL reset_b_pop_ack got %b exp 0", b_pop_ack); end
    endtask

    task automatic test_frame_latency();
        logic [9:0] words [3];
        words[0] = 10'h001; words[1] = 10'h002; words[2] = 10'h203;
        reset_both();
        a_pop_req = 1;
        for (int i = 0; i < 3; i++) begin
            a_push_req = 1; a_push_data = words[i];
            checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL lat_early_pop_ack[%0d] got %b exp 0", i, a_pop_ack); end
            tick();
        end
        a_push_req = 0;
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL lat_bubble_pop_ack got %b exp 0", a_pop_ack); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_pop_ack !== 1'b1) begin errors++; $display("FAIL lat_pop_ack[%0d] got %b exp 1", i, a_pop_ack); end
            checks++; if (a_pop_data !== words[i]) begin errors++; $display("FAIL lat_pop_data[%0d] got %h exp %h", i, a_pop_data, words[i]); end
            tick();
        end
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL lat_after_pop_ack got %b exp 0", a_pop_ack); end
        tick();
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL lat_idle_pop_ack got %b exp 0", a_pop_ack); end
        a_pop_req = 0;
    endtask

    task automatic test_full();
        reset_both();
        for (int i = 0; i < 16; i++) begin
            checks++; if (a_push_ack !== 1'b1) begin errors++; $display("FAIL full_push_ack[%0d] got %b exp 1", i, a_push_ack); end
            checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL full_closed_pop_ack[%0d] got %b exp 0", i, a_pop_ack); end
            a_push_req = 1; a_push_data = 10'(16 + i);
            tick();
        end
        checks++; if (a_push_ack !== 1'b0) begin errors++; $display("FAIL full_at16_push_ack got %b exp 0", a_push_ack); end
        a_push_data = 10'h3FF;
        tick();
        checks++; if (a_push_ack !== 1'b0) begin errors++; $display("FAIL full_refused_push_ack got %b exp 0", a_push_ack); end
        checks++; if (a_pop_ack !== 1'b1) begin errors++; $display("FAIL full_open_pop_ack got %b exp 1", a_pop_ack); end
        a_push_req = 0; a_pop_req = 1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (a_pop_ack !== 1'b1) begin errors++; $display("FAIL full_drain_ack[%0d] got %b exp 1", i, a_pop_ack); end
            checks++; if (a_pop_data !== 10'(16 + i)) begin errors++; $display("FAIL full_drain_data[%0d] got %h exp %h", i, a_pop_data, 10'(16 + i)); end
            tick();
            checks++; if (a_push_ack !== 1'b1) begin errors++; $display("FAIL full_reenable_push_ack[%0d] got %b exp 1", i, a_push_ack); end
        end
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL full_empty_pop_ack got %b exp 0", a_pop_ack); end
        a_pop_req = 0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] words [3];
        words[0] = 10'h011; words[1] = 10'h212; words[2] = 10'h223;
        reset_both();
        for (int i = 0; i < 3; i++) begin
            a_push_req = 1; a_push_data = words[i];
            tick();
        end
        a_push_req = 0;
        checks++; if (a_pop_ack !== 1'b1) begin errors++; $display("FAIL b2b_open_pop_ack got %b exp 1", a_pop_ack); end
        a_pop_req = 1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (a_pop_data !== words[i]) begin errors++; $display("FAIL b2b_f1_data[%0d] got %h exp %h", i, a_pop_data, words[i]); end
            checks++; if (a_pop_ack !== 1'b1) begin errors++; $display("FAIL b2b_f1_ack[%0d] got %b exp 1", i, a_pop_ack); end
            tick();
        end
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL b2b_bubble_pop_ack got %b exp 0", a_pop_ack); end
        tick();
        checks++; if (a_pop_ack !== 1'b1) begin errors++; $display("FAIL b2b_f2_ack got %b exp 1", a_pop_ack); end
        checks++; if (a_pop_data !== words[2]) begin errors++; $display("FAIL b2b_f2_data got %h exp %h", a_pop_data, words[2]); end
        tick();
        tick();
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL b2b_done_pop_ack got %b exp 0", a_pop_ack); end
        a_pop_req = 0;
    endtask

    task automatic test_threshold();
        reset_both();
        for (int i = 0; i < 4; i++) begin
            b_push_req = 1; b_push_data = 10'(8'h31 + i);
            tick();
        end
        b_push_req = 0;
        checks++; if (b_pop_ack !== 1'b0) begin errors++; $display("FAIL thr_not_yet_pop_ack got %b exp 0", b_pop_ack); end
        tick();
        b_pop_req = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (b_pop_ack !== 1'b1) begin errors++; $display("FAIL thr_pop_ack[%0d] got %b exp 1", i, b_pop_ack); end
            checks++; if (b_pop_data !== 10'(8'h31 + i)) begin errors++; $display("FAIL thr_pop_data[%0d] got %h exp %h", i, b_pop_data, 10'(8'h31 + i)); end
            tick();
        end
        checks++; if (b_pop_ack !== 1'b0) begin errors++; $display("FAIL thr_stall_pop_ack got %b exp 0", b_pop_ack); end
        tick();
        b_push_req = 1; b_push_data = 10'h205;
        tick();
        checks++; if (b_pop_ack !== 1'b1) begin errors++; $display("FAIL thr_send_kept_pop_ack got %b exp 1", b_pop_ack); end
        checks++; if (b_pop_data !== 10'h205) begin errors++; $display("FAIL thr_marker_data got %h exp 205", b_pop_data); end
        b_push_data = 10'h206;
        tick();
        b_push_req = 0;
        checks++; if (b_pop_ack !== 1'b0) begin errors++; $display("FAIL thr_idle_bubble_pop_ack got %b exp 0", b_pop_ack); end
        tick();
        checks++; if (b_pop_ack !== 1'b1) begin errors++; $display("FAIL thr_next_pop_ack got %b exp 1", b_pop_ack); end
        checks++; if (b_pop_data !== 10'h206) begin errors++; $display("FAIL thr_next_data got %h exp 206", b_pop_data); end
        tick();
        checks++; if (b_pop_ack !== 1'b0) begin errors++; $display("FAIL thr_end_pop_ack got %b exp 0", b_pop_ack); end
        b_pop_req = 0;
    endtask

    task automatic test_stream_wrap();
        reset_both();
        for (int i = 0; i < 8; i++) begin
            b_push_req = 1; b_push_data = 10'(8'h40 + i);
            tick();
        end
        b_push_req = 0;
        tick();
        b_pop_req = 1; b_push_req = 1;
        for (int i = 0; i < 20; i++) begin
            b_push_data = 10'(8'h48 + i);
            checks++; if (b_push_ack !== 1'b1 || b_pop_ack !== 1'b1) begin errors++; $display("FAIL wrap_acks[%0d] got %b%b exp 11", i, b_push_ack, b_pop_ack); end
            checks++; if (b_pop_data !== 10'(8'h40 + i)) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, b_pop_data, 10'(8'h40 + i)); end
            tick();
        end
        b_push_req = 0;
        for (int i = 20; i < 28; i++) begin
            checks++; if (b_pop_data !== 10'(8'h40 + i) || b_pop_ack !== 1'b1) begin errors++; $display("FAIL wrap_drain[%0d] got %h/%b exp %h/1", i, b_pop_data, b_pop_ack, 10'(8'h40 + i)); end
            tick();
        end
        checks++; if (b_pop_ack !== 1'b0) begin errors++; $display("FAIL wrap_count8_pop_ack got %b exp 0", b_pop_ack); end
        b_pop_req = 0;
    endtask

    task automatic test_reset_midframe();
        reset_both();
        a_push_req = 1; a_push_data = 10'h250;
        tick();
        for (int i = 0; i < 4; i++) begin
            a_push_data = 10'(8'h60 + i);
            tick();
        end
        a_push_req = 0;
        a_reset = 1;
        tick();
        a_reset = 0;
        checks++; if (a_push_ack !== 1'b1) begin errors++; $display("FAIL mid_reset_push_ack got %b exp 1", a_push_ack); end
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_pop_ack got %b exp 0", a_pop_ack); end
        tick();
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_frames_pop_ack got %b exp 0", a_pop_ack); end
        a_push_req = 1; a_push_data = 10'h0AA;
        tick();
        a_push_data = 10'h2BB;
        tick();
        a_push_req = 0;
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL mid_new_bubble_pop_ack got %b exp 0", a_pop_ack); end
        tick();
        a_pop_req = 1;
        checks++; if (a_pop_ack !== 1'b1 || a_pop_data !== 10'h0AA) begin errors++; $display("FAIL mid_new_first got %h/%b exp 0aa/1", a_pop_data, a_pop_ack); end
        tick();
        checks++; if (a_pop_ack !== 1'b1 || a_pop_data !== 10'h2BB) begin errors++; $display("FAIL mid_new_last got %h/%b exp 2bb/1", a_pop_data, a_pop_ack); end
        tick();
        checks++; if (a_pop_ack !== 1'b0) begin errors++; $display("FAIL mid_new_done_pop_ack got %b exp 0", a_pop_ack); end
        a_pop_req = 0;
    endtask

    initial begin
        a_reset = 1; b_reset = 1;
        a_push_req = 0; a_pop_req = 0; a_push_data = '0;
        b_push_req = 0; b_pop_req = 0; b_push_data = '0;
        test_reset();
        test_frame_latency();
        test_full();
        test_back_to_back();
        test_threshold();
        test_stream_wrap();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
